// File: rtl/pong_ball_engine.sv
// Pong ball physics and scoring: serve countdown, per-tick motion with wall bounce,
// paddle collision, point award and game-over handling.
module pong_ball_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 10,
  parameter int PADDLE_W    = 10,
  parameter int PADDLE_H    = 50,
  parameter int P1_X        = 20,
  parameter int P2_X        = 620,
  parameter int SPEED       = 2,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        serve,
  input  logic [9:0]  p1_pos,
  input  logic [9:0]  p2_pos,
  output logic [10:0] ball_x,
  output logic [9:0]  ball_y,
  output logic [3:0]  p1_score,
  output logic [3:0]  p2_score,
  output logic        point_p1,
  output logic        point_p2,
  output logic        game_over
);

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  localparam logic [11:0] SW    = 12'(SCREEN_W);
  localparam logic [11:0] BS    = 12'(BALL_SIZE);
  localparam logic [11:0] PW    = 12'(PADDLE_W);
  localparam logic [11:0] PH    = 12'(PADDLE_H);
  localparam logic [11:0] X1    = 12'(P1_X);
  localparam logic [11:0] X2    = 12'(P2_X);
  localparam logic [11:0] SPD   = 12'(SPEED);
  localparam logic [11:0] Y_MAX = 12'(SCREEN_H - BALL_SIZE);

  localparam logic [10:0] X_CTR = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [3:0]  WIN   = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_MOVE  = 3'd2,
    S_CHECK = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [10:0]        x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic               dx_q, dx_d;     // 1 = moving right
  logic               dy_q, dy_d;     // 1 = moving down
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         p1s_q, p1s_d;
  logic [3:0]         p2s_q, p2s_d;
  logic               scorer_q, scorer_d;  // 1 = P1 took the point

  logic [11:0] x12, y12, p1_12, p2_12;
  logic        hit_l, hit_r;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  function automatic logic overlap_y(input logic [11:0] y, input logic [11:0] top);
    return ((y + BS) > top) && (y < (top + PH));
  endfunction

  assign x12   = {1'b0, x_q};
  assign y12   = {2'b0, y_q};
  assign p1_12 = {2'b0, p1_pos};
  assign p2_12 = {2'b0, p2_pos};

  assign hit_l = !dx_q && (x12 <= X1 + PW) && ((x12 + BS) > X1) && overlap_y(y12, p1_12);
  assign hit_r =  dx_q && ((x12 + BS) >= X2) && (x12 < X2 + PW) && overlap_y(y12, p2_12);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;
    p1s_d    = p1s_q;
    p2s_d    = p2s_q;
    scorer_d = scorer_q;

    case (state_q)
      S_IDLE: begin
        x_d = X_CTR;
        y_d = Y_CTR;
        if (serve) begin
          state_d = S_SERVE;
          dx_d    = 1'b1;
          dy_d    = 1'b1;
          cnt_d   = '0;
        end
      end

      S_SERVE: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_MOVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_MOVE: begin
        if (tick) begin
          state_d = S_CHECK;
          if (dx_q)            x_d = 11'(x12 + SPD);
          else if (x12 < SPD)  x_d = '0;
          else                 x_d = 11'(x12 - SPD);

          if (dy_q) begin
            if ((y12 + SPD) >= Y_MAX) begin
              y_d  = 10'(Y_MAX);
              dy_d = 1'b0;
            end else begin
              y_d = 10'(y12 + SPD);
            end
          end else begin
            if (y12 <= SPD) begin
              y_d  = '0;
              dy_d = 1'b1;
            end else begin
              y_d = 10'(y12 - SPD);
            end
          end
        end
      end

      // Paddle hits take priority over the edge test so a return at the wall still counts.
      S_CHECK: begin
        if (hit_l) begin
          x_d     = 11'(X1 + PW);
          dx_d    = 1'b1;
          state_d = S_MOVE;
        end else if (hit_r) begin
          x_d     = 11'(X2 - BS);
          dx_d    = 1'b0;
          state_d = S_MOVE;
        end else if (x12 == 12'd0) begin
          scorer_d = 1'b0;
          state_d  = S_POINT;
        end else if ((x12 + BS) >= SW) begin
          scorer_d = 1'b1;
          state_d  = S_POINT;
        end else begin
          state_d = S_MOVE;
        end
      end

      S_POINT: begin
        x_d   = X_CTR;
        y_d   = Y_CTR;
        cnt_d = '0;
        if (scorer_q) begin
          p1s_d   = sat_inc(p1s_q);
          dx_d    = 1'b1;
          state_d = (sat_inc(p1s_q) == WIN) ? S_OVER : S_SERVE;
        end else begin
          p2s_d   = sat_inc(p2s_q);
          dx_d    = 1'b0;
          state_d = (sat_inc(p2s_q) == WIN) ? S_OVER : S_SERVE;
        end
      end

      S_OVER: begin
        x_d = X_CTR;
        y_d = Y_CTR;
        if (serve) begin
          p1s_d   = '0;
          p2s_d   = '0;
          dx_d    = 1'b1;
          dy_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_SERVE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= X_CTR;
      y_q      <= Y_CTR;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      cnt_q    <= '0;
      p1s_q    <= '0;
      p2s_q    <= '0;
      scorer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
      p1s_q    <= p1s_d;
      p2s_q    <= p2s_d;
      scorer_q <= scorer_d;
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign p1_score  = p1s_q;
  assign p2_score  = p2s_q;
  assign point_p1  = (state_q == S_POINT) &&  scorer_q;
  assign point_p2  = (state_q == S_POINT) && !scorer_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
Ball physics and scoring engine for the pong game loop; it fills the update-ball and check-collision steps. It consumes paddle Y positions from the potentiometer scaling stage and produces the ball rectangle position for the ball render object, plus per-player scores for the SSD/LED display. It advances one step per game tick, a one-cycle strobe derived from the divided clock.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BALL_SIZE, 10, ball width and height
PADDLE_W, 10, paddle width
PADDLE_H, 50, paddle height
P1_X, 20, left paddle X
P2_X, 620, right paddle X
SPEED, 2, pixels per tick on each axis
WIN_SCORE, 9, score that ends the game (max 15)
SERVE_DELAY, 60, ticks waited before ball moves after serve/point

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-cycle game-step strobe
serve  in  1  one-cycle start/restart pulse
p1_pos  in  10  left paddle top Y (0..430)
p2_pos  in  10  right paddle top Y (0..430)
ball_x  out  11  ball left X
ball_y  out  10  ball top Y
p1_score  out  4  left player score
p2_score  out  4  right player score
point_p1  out  1  one-cycle pulse, P1 scored
point_p2  out  1  one-cycle pulse, P2 scored
game_over  out  1  high while in OVER

Behaviour:
- Reset values: ball_x=315, ball_y=235, scores=0, pulses=0, game_over=0, dx=right, dy=down, serve counter=0, state IDLE. Reset mid-operation aborts immediately.
- All comparisons use 12-bit zero-extended operands, so there is no wrap.
- IDLE: ball held at center. serve -> SERVE with dx=right, dy=down. A tick in IDLE does nothing. serve and tick in the same cycle: serve wins and the tick is not counted.
- SERVE: counter increments on each tick. The tick that makes the count equal SERVE_DELAY clears the counter and enters MOVE with no motion on that tick.
- MOVE, on tick (ball registers updated the next edge, state -> CHECK):
  - x: right -> x+SPEED. Left -> x-SPEED, clamped at 0.
  - y: down, if y+SPEED >= SCREEN_H-BALL_SIZE -> y=SCREEN_H-BALL_SIZE and dy=up; else y+SPEED.
  - y: up, if y <= SPEED -> y=0 and dy=down; else y-SPEED.
- CHECK (exactly one cycle, p1_pos/p2_pos sampled here, priority top-down):
  - Left hit: dx=left, x <= P1_X+PADDLE_W, x+BALL_SIZE > P1_X, y+BALL_SIZE > p1_pos, y < p1_pos+PADDLE_H. Action: x=P1_X+PADDLE_W, dx=right -> MOVE.
  - Right hit: dx=right, x+BALL_SIZE >= P2_X, x < P2_X+PADDLE_W, vertical overlap with p2_pos. Action: x=P2_X-BALL_SIZE, dx=left -> MOVE.
  - x == 0 -> POINT, P2 scores.
  - x+BALL_SIZE >= SCREEN_W -> POINT, P1 scores.
  - Otherwise -> MOVE.
- POINT (one cycle):
  - Increment the scorer's score and pulse point_pX for exactly this cycle.
  - Ball -> (315,235). dx points toward the conceding player; dy unchanged.
  - If the new score == WIN_SCORE -> OVER, else -> SERVE.
- OVER: game_over=1, ball frozen at center, ticks ignored. serve -> clear both scores, game_over=0, dx=right, dy=down, SERVE.
- Ticks arriving in CHECK or POINT are dropped.
- serve in SERVE, MOVE, CHECK or POINT is ignored.
- Scores saturate at WIN_SCORE; they never wrap.

Test Plan:
- Reset, then 10 ticks with no serve -> ball (315,235), scores 0/0, game_over 0; no movement.
- SERVE_DELAY=4: serve, 4 ticks -> ball static at (315,235). 5th tick -> (317,237) one cycle later.
- Ball moving up at y=1, tick -> y=0 and dy=down. Next tick -> y=2.
- p2_pos=220, ball y=230 moving right reaching x=612 -> x=610, dx=left, no point pulse, scores unchanged.
- p2_pos=0, ball y=300 moving right until x+10>=640 -> point_p1 high exactly 1 cycle, p1_score=1, ball (315,235), dx=right, state SERVE.
- p1_score=8, P1 scores again -> p1_score=9, game_over=1, subsequent ticks leave ball static. serve -> scores 0/0, game_over=0.
